alu_issue_stage: RTL
====================

Name: alu_issue_stage

Overview:
- Decode/issue stage directly upstream of the 32-bit ALU built from alu_bottom/alu_top slices.
- Holds the 32x32 register file, decodes the instruction into the ALU slice control bundle (operation, func, A_invert, B_invert, cin), and selects operands.
- Registers everything into one pipeline register with a valid/ready handshake toward the execute stage.

Parameters:
- DATA_W, 32, operand/register width.
- REG_N, 32, number of architectural registers; r0 reads as zero.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous active-high reset.
- id_valid_i  in  1  instruction word valid.
- id_ready_o  out  1  stage can accept an instruction this cycle.
- id_instr_i  in  32  instruction (MIPS-format R/I).
- wb_wen_i  in  1  writeback enable.
- wb_addr_i  in  5  writeback register.
- wb_data_i  in  DATA_W  writeback data.
- ex_valid_o  out  1  issue register holds a valid op.
- ex_ready_i  in  1  ALU stage consumes the op this cycle.
- ex_src1_o  out  DATA_W  ALU src1.
- ex_src2_o  out  DATA_W  ALU src2 (rt value or sign-extended imm16).
- ex_operation_o  out  4  ALU operation code.
- ex_func_o  out  3  ALU compare sub-function.
- ex_a_invert_o  out  1  A_invert.
- ex_b_invert_o  out  1  B_invert.
- ex_cin_o  out  1  carry into bit 0.
- ex_rd_o  out  5  destination register.
- ex_wen_o  out  1  op writes a register.
- ex_illegal_o  out  1  opcode/funct not supported; op issued as bubble.

Behaviour:
- Reset: all issue-register outputs 0, ex_valid_o=0; every register-file entry 0.
- id_ready_o = !ex_valid_o || ex_ready_i (combinational). Transfer occurs when id_valid_i && id_ready_o.
- On transfer: capture decode into the issue register next edge and set ex_valid_o=1; latency is 1 cycle.
- No transfer but ex_ready_i=1: clear ex_valid_o; data outputs hold.
- ex_valid_o && !ex_ready_i: all ex_* outputs hold stable.
- Register file write: on every edge where wb_wen_i && wb_addr_i!=0, independent of stall. Writes to r0 are ignored.
- Read bypass: if wb_wen_i, wb_addr_i!=0 and wb_addr_i equals rs (or rt), the read returns wb_data_i in the same cycle.
- R-type (opcode 0x00): src1=rs, src2=rt, rd=instr[15:11], wen=1. Decode by funct as operation/func/Ainv/Binv/cin:
  - 0x20 add: 0010/000/0/0/0
  - 0x22 sub: 0110/000/0/1/1
  - 0x24 and: 0000/000/0/0/0
  - 0x25 or: 0001/000/0/0/0
  - 0x27 nor: 1100/000/1/1/0
  - 0x28 nand: 1101/000/1/1/0
  - 0x2A slt: 0111/000/0/1/1
  - 0x2B sltu: 0111/110/0/1/1
  - 0x2C sle: 0111/001/0/1/1
  - 0x2D sleu: 0111/111/0/1/1
  - 0x2E seq: 0111/011/0/1/1
  - 0x2F sne: 0111/010/0/1/1
- I-type: src2 = sign-extend(instr[15:0]), rd=instr[20:16], wen=1.
  - 0x08 addi: decoded as add.
  - 0x0A slti: decoded as slt.
- Any other opcode/funct: ex_illegal_o=1, ex_wen_o=0, control fields 0. The op still occupies the slot and handshakes normally.
- rd=0 with wen=1 is legal; downstream discards the write.
- Reset asserted mid-stall: reset wins; the held op is dropped and ex_valid_o=0 next edge.

Decomposition:
- Shared package alu_pkg holds:
  - ALU operation codes OP_AND/OP_OR/OP_ADD/OP_SUB/OP_CMP/OP_NOR/OP_NAND.
  - Compare func codes.
  - Opcode/funct constants.
  - The control-bundle struct.
- One combinational sub-module alu_ctrl_decode (instr -> control bundle, illegal). The register file stays inline.

Test Plan:
- Reset, then write r5=0x0000_0007 and r6=0xFFFF_FFFF, then issue sub r1,r5,r6. Expect ex_src1=7, ex_src2=0xFFFFFFFF, op=0110, Binv=1, cin=1, rd=1, one cycle after the handshake.
- Same-cycle bypass: wb writes r3=0x1234 while add r2,r3,r0 is accepted. Expect ex_src1=0x1234.
- Write r0=0xDEAD, then issue or r4,r0,r0. Expect ex_src1=ex_src2=0.
- addi r7,r0,-2. Expect ex_src2=0xFFFF_FFFE, op=0010, rd=7.
- Stall: hold ex_ready_i=0 for 3 cycles with a second instruction pending. Expect id_ready_o=0 and ex_* stable. Raise ex_ready_i: the second op appears the next cycle with no loss or duplication.
- Illegal funct 0x3F: ex_illegal_o=1, ex_wen_o=0, ex_valid_o=1. Assert rst_i during a stall: ex_valid_o=0 next edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU decode/issue path.
//   - ALU operation codes and compare sub-function codes seen by the
//     alu_bottom/alu_top slices.
//   - MIPS opcode / funct constants recognised by the issue stage.
//   - ctrl_t: the per-op control bundle produced by alu_ctrl_decode.
package alu_pkg;

   // ALU slice operation codes
   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_CMP  = 4'b0111;
   localparam logic [3:0] OP_NOR  = 4'b1100;
   localparam logic [3:0] OP_NAND = 4'b1101;

   // Compare sub-function codes (only meaningful with OP_CMP)
   localparam logic [2:0] FN_LT  = 3'b000;
   localparam logic [2:0] FN_LE  = 3'b001;
   localparam logic [2:0] FN_NE  = 3'b010;
   localparam logic [2:0] FN_EQ  = 3'b011;
   localparam logic [2:0] FN_LTU = 3'b110;
   localparam logic [2:0] FN_LEU = 3'b111;

   // Opcodes
   localparam logic [5:0] OPC_RTYPE = 6'h00;
   localparam logic [5:0] OPC_ADDI  = 6'h08;
   localparam logic [5:0] OPC_SLTI  = 6'h0A;

   // R-type funct codes
   localparam logic [5:0] FUNCT_ADD  = 6'h20;
   localparam logic [5:0] FUNCT_SUB  = 6'h22;
   localparam logic [5:0] FUNCT_AND  = 6'h24;
   localparam logic [5:0] FUNCT_OR   = 6'h25;
   localparam logic [5:0] FUNCT_NOR  = 6'h27;
   localparam logic [5:0] FUNCT_NAND = 6'h28;
   localparam logic [5:0] FUNCT_SLT  = 6'h2A;
   localparam logic [5:0] FUNCT_SLTU = 6'h2B;
   localparam logic [5:0] FUNCT_SLE  = 6'h2C;
   localparam logic [5:0] FUNCT_SLEU = 6'h2D;
   localparam logic [5:0] FUNCT_SEQ  = 6'h2E;
   localparam logic [5:0] FUNCT_SNE  = 6'h2F;

   typedef struct packed {
      logic [3:0] operation;
      logic [2:0] func;
      logic       a_invert;
      logic       b_invert;
      logic       cin;
      logic       wen;
      logic       use_imm;   // src2 comes from sign-extended imm16
   } ctrl_t;

   // Legal register-writing op with rt as src2.
   function automatic ctrl_t mk_ctrl(input logic [3:0] op, input logic [2:0] fn,
                                     input logic ai, input logic bi, input logic ci);
      ctrl_t c;
      c.operation = op;
      c.func      = fn;
      c.a_invert  = ai;
      c.b_invert  = bi;
      c.cin       = ci;
      c.wen       = 1'b1;
      c.use_imm   = 1'b0;
      return c;
   endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational instruction decoder: MIPS R/I word -> ALU control bundle.
// Ports:
//   i_instr   : 32-bit instruction word
//   o_ctrl    : control bundle (operation/func/invert/cin/wen/use_imm)
//   o_rd      : destination register (instr[15:11] R-type, instr[20:16] I-type)
//   o_illegal : unsupported opcode/funct; o_ctrl and o_rd forced to 0
module alu_ctrl_decode
   import alu_pkg::*;
(
   input  logic [31:0] i_instr,
   output ctrl_t       o_ctrl,
   output logic [4:0]  o_rd,
   output logic        o_illegal
);

   logic [5:0] w_opc;
   logic [5:0] w_funct;
   ctrl_t      w_ctrl;
   logic [4:0] w_rd;
   logic       w_ill;

   assign w_opc   = i_instr[31:26];
   assign w_funct = i_instr[5:0];

   always_comb begin
      w_ctrl = '0;
      w_rd   = '0;
      w_ill  = 1'b0;
      case (w_opc)
         OPC_RTYPE: begin
            w_rd = i_instr[15:11];
            case (w_funct)
               FUNCT_ADD:  w_ctrl = mk_ctrl(OP_ADD,  FN_LT,  1'b0, 1'b0, 1'b0);
               FUNCT_SUB:  w_ctrl = mk_ctrl(OP_SUB,  FN_LT,  1'b0, 1'b1, 1'b1);
               FUNCT_AND:  w_ctrl = mk_ctrl(OP_AND,  FN_LT,  1'b0, 1'b0, 1'b0);
               FUNCT_OR:   w_ctrl = mk_ctrl(OP_OR,   FN_LT,  1'b0, 1'b0, 1'b0);
               FUNCT_NOR:  w_ctrl = mk_ctrl(OP_NOR,  FN_LT,  1'b1, 1'b1, 1'b0);
               FUNCT_NAND: w_ctrl = mk_ctrl(OP_NAND, FN_LT,  1'b1, 1'b1, 1'b0);
               FUNCT_SLT:  w_ctrl = mk_ctrl(OP_CMP,  FN_LT,  1'b0, 1'b1, 1'b1);
               FUNCT_SLTU: w_ctrl = mk_ctrl(OP_CMP,  FN_LTU, 1'b0, 1'b1, 1'b1);
               FUNCT_SLE:  w_ctrl = mk_ctrl(OP_CMP,  FN_LE,  1'b0, 1'b1, 1'b1);
               FUNCT_SLEU: w_ctrl = mk_ctrl(OP_CMP,  FN_LEU, 1'b0, 1'b1, 1'b1);
               FUNCT_SEQ:  w_ctrl = mk_ctrl(OP_CMP,  FN_EQ,  1'b0, 1'b1, 1'b1);
               FUNCT_SNE:  w_ctrl = mk_ctrl(OP_CMP,  FN_NE,  1'b0, 1'b1, 1'b1);
               default:    w_ill  = 1'b1;
            endcase
         end
         OPC_ADDI: begin
            w_rd           = i_instr[20:16];
            w_ctrl         = mk_ctrl(OP_ADD, FN_LT, 1'b0, 1'b0, 1'b0);
            w_ctrl.use_imm = 1'b1;
         end
         OPC_SLTI: begin
            w_rd           = i_instr[20:16];
            w_ctrl         = mk_ctrl(OP_CMP, FN_LT, 1'b0, 1'b1, 1'b1);
            w_ctrl.use_imm = 1'b1;
         end
         default: w_ill = 1'b1;
      endcase
      // Illegal ops travel as a bubble: no control, no write.
      if (w_ill) begin
         w_ctrl = '0;
         w_rd   = '0;
      end
   end

   assign o_ctrl    = w_ctrl;
   assign o_rd      = w_rd;
   assign o_illegal = w_ill;

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage in front of the 32-bit slice ALU.
// Holds the register file (r0 reads zero, same-cycle writeback bypass),
// decodes the instruction and registers operands + control into a single
// issue register handshaked with the execute stage.
// Ports:
//   clk_i, rst_i                  : clock, synchronous active-high reset
//   id_valid_i/id_ready_o/id_instr_i : instruction input handshake
//   wb_wen_i/wb_addr_i/wb_data_i  : register writeback (independent of stall)
//   ex_valid_o/ex_ready_i         : issue register handshake
//   ex_src1_o, ex_src2_o          : operands
//   ex_operation_o, ex_func_o, ex_a_invert_o, ex_b_invert_o, ex_cin_o : ALU control
//   ex_rd_o, ex_wen_o, ex_illegal_o : destination, write enable, illegal flag
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_N  = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              id_valid_i,
   output logic              id_ready_o,
   input  logic [31:0]       id_instr_i,
   input  logic              wb_wen_i,
   input  logic [4:0]        wb_addr_i,
   input  logic [DATA_W-1:0] wb_data_i,
   output logic              ex_valid_o,
   input  logic              ex_ready_i,
   output logic [DATA_W-1:0] ex_src1_o,
   output logic [DATA_W-1:0] ex_src2_o,
   output logic [3:0]        ex_operation_o,
   output logic [2:0]        ex_func_o,
   output logic              ex_a_invert_o,
   output logic              ex_b_invert_o,
   output logic              ex_cin_o,
   output logic [4:0]        ex_rd_o,
   output logic              ex_wen_o,
   output logic              ex_illegal_o
);

   logic [DATA_W-1:0] r_rf [REG_N];
   logic              r_valid;
   logic [DATA_W-1:0] r_src1, r_src2;
   ctrl_t             r_ctrl;
   logic [4:0]        r_rd;
   logic              r_ill;

   logic [4:0]        w_rs, w_rt;
   logic              w_wb_act;
   logic [DATA_W-1:0] w_rs_val, w_rt_val, w_imm, w_src2;
   ctrl_t             w_ctrl;
   logic [4:0]        w_rd;
   logic              w_ill;
   logic              w_xfer;

   alu_ctrl_decode u_dec (
      .i_instr   (id_instr_i),
      .o_ctrl    (w_ctrl),
      .o_rd      (w_rd),
      .o_illegal (w_ill)
   );

   assign w_rs     = id_instr_i[25:21];
   assign w_rt     = id_instr_i[20:16];
   assign w_wb_act = wb_wen_i && (wb_addr_i != 5'd0);
   assign w_imm    = {{(DATA_W-16){id_instr_i[15]}}, id_instr_i[15:0]};

   // r0 is never written, but decode it explicitly so bypass can't leak into it.
   assign w_rs_val = (w_rs == 5'd0)                  ? '0 :
                     (w_wb_act && wb_addr_i == w_rs) ? wb_data_i : r_rf[w_rs];
   assign w_rt_val = (w_rt == 5'd0)                  ? '0 :
                     (w_wb_act && wb_addr_i == w_rt) ? wb_data_i : r_rf[w_rt];
   assign w_src2   = w_ctrl.use_imm ? w_imm : w_rt_val;

   assign id_ready_o = !r_valid || ex_ready_i;
   assign w_xfer     = id_valid_i && id_ready_o;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < REG_N; i++) r_rf[i] <= '0;
      end else if (w_wb_act) begin
         r_rf[wb_addr_i] <= wb_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_valid <= 1'b0;
         r_src1  <= '0;
         r_src2  <= '0;
         r_ctrl  <= '0;
         r_rd    <= '0;
         r_ill   <= 1'b0;
      end else if (w_xfer) begin
         r_valid <= 1'b1;
         r_src1  <= w_rs_val;
         r_src2  <= w_src2;
         r_ctrl  <= w_ctrl;
         r_rd    <= w_rd;
         r_ill   <= w_ill;
      end else if (ex_ready_i) begin
         r_valid <= 1'b0;   // consumed, nothing new: data fields hold
      end
   end

   assign ex_valid_o     = r_valid;
   assign ex_src1_o      = r_src1;
   assign ex_src2_o      = r_src2;
   assign ex_operation_o = r_ctrl.operation;
   assign ex_func_o      = r_ctrl.func;
   assign ex_a_invert_o  = r_ctrl.a_invert;
   assign ex_b_invert_o  = r_ctrl.b_invert;
   assign ex_cin_o       = r_ctrl.cin;
   assign ex_rd_o        = r_rd;
   assign ex_wen_o       = r_ctrl.wen;
   assign ex_illegal_o   = r_ill;

endmodule
